// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test controller: FSM state encoding,
// dut_out bit positions, and vector/counter sizing.
package gate_test_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCheck,
        StDone
    } state_e;

    // Bit positions inside dut_out / expected
    localparam int unsigned AND_B  = 0;
    localparam int unsigned OR_B   = 1;
    localparam int unsigned NAND_B = 2;
    localparam int unsigned NOR_B  = 3;
    localparam int unsigned XOR_B  = 4;

    // Exhaustive 3-input stimulus
    localparam int unsigned NVEC  = 8;
    localparam int unsigned VEC_W = 3;
    localparam int unsigned OUT_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the gate datapath: one stimulus vector
// {a,b,c} in, the five expected gate outputs out.
module gate_ref_model
    import gate_test_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [OUT_W-1:0] expected
);

    logic a;
    logic b;
    logic c;

    assign a = vec[2];
    assign b = vec[1];
    assign c = vec[0];

    // Ideal gate responses, placed at their dut_out bit positions
    always_comb begin
        expected         = '0;
        expected[AND_B]  = a & b & c;
        expected[OR_B]   = a | b | c;
        expected[NAND_B] = ~(a & b & c);
        expected[NOR_B]  = ~(a | b | c);
        expected[XOR_B]  = a ^ b ^ c;
    end

endmodule

// File: rtl/gate_test_ctrl.sv
// Gate test controller: steps through all 3-bit vectors, holds each for
// SETTLE_CYCLES, compares dut_out against the reference model and reports
// error count plus the first failing vector and its bit mask.
// Optional build macro GATE_TEST_STOP_ON_FAIL_EN: end the run at the first
// mismatching vector instead of applying all eight.
module gate_test_ctrl
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] dut_out,
    output logic [VEC_W-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] fail_vec,
    output logic [OUT_W-1:0] fail_mask
);

    // Last value of the settle counter before moving on to CHECK
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q;
    logic [VEC_W-1:0] vec_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [VEC_W-1:0] fail_vec_q;
    logic [OUT_W-1:0] fail_mask_q;
    logic [CNT_W-1:0] settle_cnt_q;

    logic [OUT_W-1:0] expected;
    logic [OUT_W-1:0] diff;
    logic             mismatch;
    logic             halt;
    logic             last_vec;

    gate_ref_model u_ref (
        .vec      (vec_q),
        .expected (expected)
    );

    // Compare logic; only consumed in StCheck so dut_out is ignored elsewhere
    assign diff     = expected ^ dut_out;
    assign mismatch = |diff;
    assign last_vec = (vec_q == LAST_VEC);

`ifdef GATE_TEST_STOP_ON_FAIL_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_mask_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= StApply;
                        vec_q        <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_cnt_q    <= '0;
                        fail_vec_q   <= '0;
                        fail_mask_q  <= '0;
                        settle_cnt_q <= '0;
                    end
                end
                StApply: begin
                    state_q      <= StSettle;
                    settle_cnt_q <= '0;
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q      <= StCheck;
                        settle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_cnt_q <= err_cnt_q + 4'd1;
                        // Only the first failing vector is recorded
                        if (err_cnt_q == '0) begin
                            fail_vec_q  <= vec_q;
                            fail_mask_q <= diff;
                        end
                    end
                    if (halt || last_vec) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && (err_cnt_q == '0);
                    end else begin
                        state_q <= StApply;
                        vec_q   <= vec_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_test_ctrl.sv
// Scoreboard bench for gate_test_ctrl: each accepted start pushes the
// expected run result; a monitor pops and compares when done rises.
module tb_gate_test_ctrl;

    localparam int unsigned S   = 2;
    localparam int unsigned PER = S + 2;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] dut_out = '0;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;
    logic [4:0] fail_mask;

    gate_test_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_out   (dut_out),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_vec  (fail_vec),
        .fail_mask (fail_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err;
        int fvec;
        int fmask;
        int pass;
        int last_vec;
        int cycles;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [4:0] pat [8];   // per-vector error pattern seen in CHECK
    bit         noise = 1'b0;

    function automatic logic [4:0] gates(input int v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return {a ^ b ^ c, ~(a | b | c), ~(a & b & c), a | b | c, a & b & c};
    endfunction

    // Whole-run result from the observed response of every vector
    function automatic exp_t model();
        exp_t e;
        logic [4:0] obs;
        int n;
        e = '{0, 0, 0, 0, 0, 0};
        n = 0;
        for (int v = 0; v < 8; v++) begin
            obs = gates(v) ^ pat[v];
            e.last_vec = v;
            n++;
            if (obs != gates(v)) begin
                if (e.err == 0) begin
                    e.fvec  = v;
                    e.fmask = int'(obs ^ gates(v));
                end
                e.err++;
                if (STOP) break;
            end
        end
        e.pass   = (e.err == 0) ? 1 : 0;
        e.cycles = n * PER;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Gate datapath stand-in: faulty value in CHECK, optional noise elsewhere
    int rc = 0;
    always @(negedge clk) begin
        int idx;
        logic [4:0] fault;
        idx   = (rc / PER) % 8;
        fault = gates(idx) ^ pat[idx];
        if (busy && (rc % PER) == PER - 1) dut_out = fault;
        else if (noise)                    dut_out = 5'($urandom);
        else                               dut_out = fault;
        rc = busy ? rc + 1 : 0;
    end

    // Monitor: busy length, vec stepping, and run result on done rising
    int bcyc = 0;
    int vec_err = 0;
    bit done_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bcyc    = 0;
            vec_err = 0;
            done_d  = 1'b0;
        end else begin
            if (busy) begin
                if (vec != 3'(bcyc / PER)) vec_err++;
                bcyc++;
            end
            if (done && !done_d) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("err_cnt", int'(err_cnt), e.err);
                    chk("fail_vec", int'(fail_vec), e.fvec);
                    chk("fail_mask", int'(fail_mask), e.fmask);
                    chk("pass", int'(pass), e.pass);
                    chk("final_vec", int'(vec), e.last_vec);
                    chk("busy_cycles", bcyc, e.cycles);
                    chk("vec_sequence_errors", vec_err, 0);
                end
                bcyc    = 0;
                vec_err = 0;
            end
            done_d = done;
        end
    end

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=done_low required=done_high");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_one();
        exp_q.push_back(model());
        do_start();
        wait_done();
    endtask

    task automatic clear_pat();
        for (int v = 0; v < 8; v++) pat[v] = '0;
    endtask

    initial begin
        bit seen;
        clear_pat();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vec", int'(vec), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_fail_vec", int'(fail_vec), 0);
        chk("rst_fail_mask", int'(fail_mask), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal gates
        run_one();

        // OR output stuck at 0
        for (int v = 0; v < 8; v++) pat[v] = gates(v) & 5'b00010;
        run_one();

        // XOR output inverted
        for (int v = 0; v < 8; v++) pat[v] = 5'b10000;
        run_one();

        // Noise outside CHECK only
        clear_pat();
        noise = 1'b1;
        run_one();
        noise = 1'b0;

        // Start while busy is ignored
        exp_q.push_back(model());
        do_start();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();

        // Start from DONE clears done and reruns
        exp_q.push_back(model());
        do_start();
        chk("restart_done_cleared", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        wait_done();

        // Reset in SETTLE of vector 4
        exp_q.push_back(model());
        do_start();
        repeat (17) @(negedge clk);
        chk("pre_reset_vec", int'(vec), 4);
        #1 rst = 1'b1;
        #1;
        chk("arst_vec", int'(vec), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_pass", int'(pass), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_run_after_reset", int'(seen), 0);
        run_one();

        // Randomised fault patterns and noise
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 8; v++)
                pat[v] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            noise = 1'($urandom_range(0, 1));
            run_one();
        end
        noise = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
